// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction-side datapath.
// Used by the fetch unit and the control unit decoder.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 16;

    // Major opcode field, instr[15:14]
    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_LIB = 2'b10;
    localparam logic [1:0] OP_ALU = 2'b11;

    // Conditional branch group, instr[15:11]
    localparam logic [4:0] BR_COND = 5'b10111;

    // Branch condition codes
    localparam logic [1:0] COND_BE  = 2'b00;
    localparam logic [1:0] COND_BLT = 2'b01;
    localparam logic [1:0] COND_BLE = 2'b10;
    localparam logic [1:0] COND_BNE = 2'b11;

    // Fetch FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_DRAIN = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch queue: synchronous FIFO with push/pop/flush.
// Flush wins over a same-cycle push or pop.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // A full queue may still accept a push when the head leaves the same cycle
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; flush empties without touching storage
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, no reset needed since emptiness masks stale words
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, IMEM req/ack sequencer, prefetch queue.
// Redirects flush the queue and drain any stale outstanding request.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic               CLOCK,
    input  logic               RESET,
    output logic               IMEM_REQ,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    input  logic               IMEM_ACK,
    input  logic [INSTR_W-1:0] IMEM_RDATA,
    output logic [INSTR_W-1:0] EXEC,
    output logic [ADDR_W-1:0]  EXEC_PC,
    output logic               EXEC_VALID,
    input  logic               EXEC_READY,
    input  logic               BR_TAKEN,
    input  logic [ADDR_W-1:0]  BR_TARGET
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + INSTR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_imem_addr;
    logic              r_imem_req;

    logic [ENT_W-1:0]  w_head;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_cnt_after;
    logic              w_empty;
    logic              w_full;
    logic              w_ack;
    logic              w_pop;
    logic              w_push;
    logic              w_room_now;
    logic              w_room_after;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_ack    = IMEM_ACK & r_imem_req;
    assign w_pop    = ~w_empty & EXEC_READY;
    assign w_push   = w_ack & (r_state == ST_REQ) & ~BR_TAKEN;
    assign w_pc_inc = r_fetch_pc + ADDR_W'(1);

    // Occupancy once this cycle's push and pop have both landed
    assign w_cnt_after  = w_count + CNT_W'(1) - CNT_W'(w_pop);
    assign w_room_after = (w_cnt_after < DEPTH_C);
    assign w_room_now   = ~w_full | w_pop;

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLOCK),
        .i_rst   (RESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (BR_TAKEN),
        .i_data  ({r_fetch_pc, IMEM_RDATA}),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign IMEM_REQ   = r_imem_req;
    assign IMEM_ADDR  = r_imem_addr;
    assign EXEC_VALID = ~w_empty;
    assign EXEC    = w_empty ? '0 : w_head[INSTR_W-1:0];
    assign EXEC_PC = w_empty ? '0 : w_head[ENT_W-1:INSTR_W];

    // Fetch sequencer: request stays put until acked, redirects drain stale data
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (BR_TAKEN) begin
                        r_fetch_pc  <= BR_TARGET;
                        r_state     <= ST_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= BR_TARGET;
                    end else if (w_room_now) begin
                        r_state     <= ST_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_fetch_pc;
                    end
                end
                ST_REQ: begin
                    if (BR_TAKEN) begin
                        r_fetch_pc <= BR_TARGET;
                        if (w_ack) begin
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= BR_TARGET;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (w_ack) begin
                        r_fetch_pc  <= w_pc_inc;
                        r_imem_addr <= w_pc_inc;
                        if (w_room_after) begin
                            r_imem_req <= 1'b1;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_imem_req <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (BR_TAKEN) begin
                        r_fetch_pc <= BR_TARGET;
                        if (w_ack) begin
                            r_state     <= ST_REQ;
                            r_imem_req  <= 1'b1;
                            r_imem_addr <= BR_TARGET;
                        end
                    end else if (w_ack) begin
                        r_state     <= ST_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= r_fetch_pc;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a stream-level reference model.
// A second instance with RESET_PC=FFFF exercises PC wrap.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic [15:0] exec;
    logic [15:0] exec_pc;
    logic        exec_valid;
    logic        exec_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'h0;

    logic        w_req;
    logic [15:0] w_addr;
    logic        w_ack = 1'b0;
    logic [15:0] w_rdata = 16'h0;
    logic [15:0] w_exec;
    logic [15:0] w_exec_pc;
    logic        w_valid;

    int n_vec = 0;
    int n_err = 0;
    int ack_delay = 1;
    int ack_cnt = 0;
    int ack_count = 0;

    instr_fetch_unit #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000),
        .DEPTH    (DEPTH)
    ) u_dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .IMEM_REQ   (imem_req),
        .IMEM_ADDR  (imem_addr),
        .IMEM_ACK   (imem_ack),
        .IMEM_RDATA (imem_rdata),
        .EXEC       (exec),
        .EXEC_PC    (exec_pc),
        .EXEC_VALID (exec_valid),
        .EXEC_READY (exec_ready),
        .BR_TAKEN   (br_taken),
        .BR_TARGET  (br_target)
    );

    instr_fetch_unit #(
        .ADDR_W   (16),
        .RESET_PC (16'hFFFF),
        .DEPTH    (DEPTH)
    ) u_wrap (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .IMEM_REQ   (w_req),
        .IMEM_ADDR  (w_addr),
        .IMEM_ACK   (w_ack),
        .IMEM_RDATA (w_rdata),
        .EXEC       (w_exec),
        .EXEC_PC    (w_exec_pc),
        .EXEC_VALID (w_valid),
        .EXEC_READY (1'b1),
        .BR_TAKEN   (1'b0),
        .BR_TARGET  (16'h0000)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] n;
        n = a + 16'd1;
        return 16'hC000 + (n << 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, got, exp, $time);
        end
    endtask

    // Memory responders: main one acks ack_delay cycles after a request appears
    always @(posedge CLOCK) begin
        #1;
        if (RESET) begin
            imem_ack = 1'b0;
            ack_cnt  = 0;
        end else if (imem_req) begin
            if (imem_ack) ack_cnt = 0;
            if (ack_cnt >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                ack_count++;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 16'h0BAD;
                ack_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            ack_cnt  = 0;
        end
        w_ack   = !RESET && w_req;
        w_rdata = mem_word(w_addr);
    end

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ins;
    } ent_t;

    ent_t        mq[$];
    bit          started = 0;
    bit          stale = 0;
    bit          exp_hold = 0;
    bit          exp_rst = 0;
    bit          exp_first = 0;
    bit          prev_rst = 0;
    bit          m_ack;
    logic [15:0] hold_addr = 16'h0;
    logic [15:0] fetch_next = 16'h0;
    logic [15:0] wexp = 16'hFFFF;

    // Reference model: compare outputs, then advance on the upcoming edge's inputs
    always @(negedge CLOCK) begin
        if (started) begin
            chk("exec_valid", exec_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("exec_pc", exec_pc, mq[0].pc);
                chk("exec", exec, mq[0].ins);
            end else begin
                chk("exec_pc_idle", exec_pc, 0);
                chk("exec_idle", exec, 0);
            end
            if (exp_hold) begin
                chk("req_hold", imem_req, 1);
                chk("addr_hold", imem_addr, hold_addr);
            end
            if (exp_rst) begin
                chk("req_reset", imem_req, 0);
                chk("addr_reset", imem_addr, 16'h0000);
            end
            if (exp_first) begin
                chk("req_first", imem_req, 1);
                chk("addr_first", imem_addr, 16'h0000);
            end
            if (w_valid) begin
                chk("wrap_pc", w_exec_pc, wexp);
                chk("wrap_exec", w_exec, mem_word(wexp));
            end else begin
                chk("wrap_idle", {w_exec_pc, w_exec}, 0);
            end
        end
        exp_first = prev_rst && !RESET;
        exp_rst   = RESET;
        prev_rst  = RESET;
        exp_hold  = 0;
        if (RESET) begin
            mq.delete();
            stale      = 0;
            fetch_next = 16'h0000;
            wexp       = 16'hFFFF;
            started    = 1;
        end else begin
            m_ack = imem_ack && imem_req;
            if (br_taken) begin
                mq.delete();
                stale      = imem_req && !m_ack;
                fetch_next = br_target;
            end else begin
                if (mq.size() != 0 && exec_ready) void'(mq.pop_front());
                if (m_ack) begin
                    if (stale) begin
                        stale = 0;
                    end else begin
                        chk("fetch_addr", imem_addr, fetch_next);
                        mq.push_back('{imem_addr, imem_rdata});
                        fetch_next = fetch_next + 16'd1;
                        chk("queue_bound", mq.size() <= DEPTH, 1);
                    end
                end
            end
            exp_hold  = imem_req && !m_ack;
            hold_addr = imem_addr;
            if (w_valid) wexp = wexp + 16'd1;
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 30; i++) begin
            if (exec_valid) break;
            tick();
        end
        chk(name, exec_valid, 1);
    endtask

    task automatic wait_req_addr(input string name, input logic [15:0] a);
        for (int i = 0; i < 30; i++) begin
            if (imem_req && imem_addr == a) break;
            tick();
        end
        chk(name, imem_req && imem_addr == a, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Back-to-back fetch with 1-cycle ack; wrap instance runs alongside
        exec_ready = 1'b1;
        ack_delay  = 1;
        do_reset();
        chk("t1_rst_req", imem_req, 0);
        chk("t1_rst_valid", exec_valid, 0);
        chk("t1_rst_exec", {exec, exec_pc}, 0);
        chk("t1_rst_addr", imem_addr, 16'h0000);
        chk("t5_rst_addr", w_addr, 16'hFFFF);
        tick();
        chk("t1_req0", imem_req, 1);
        chk("t1_addr0", imem_addr, 16'h0000);
        chk("t5_wreq0", w_req, 1);
        chk("t5_waddr0", w_addr, 16'hFFFF);
        tick();
        chk("t5_waddr1", w_addr, 16'h0000);
        chk("t5_wvalid", w_valid, 1);
        chk("t5_wpc0", w_exec_pc, 16'hFFFF);
        tick();
        chk("t5_wpc1", w_exec_pc, 16'h0000);
        chk("t1_valid0", exec_valid, 1);
        chk("t1_exec0", exec, 16'hC010);
        chk("t1_pc0", exec_pc, 16'h0000);
        chk("t1_addr1", imem_addr, 16'h0001);
        tick();
        wait_valid("t1_valid1");
        chk("t1_exec1", exec, 16'hC020);
        chk("t1_pc1", exec_pc, 16'h0001);

        // Consumer stalled: queue fills to DEPTH, then one pop frees a slot
        exec_ready = 1'b0;
        ack_delay  = 0;
        do_reset();
        ack_count = 0;
        repeat (8) tick();
        chk("t2_acks", ack_count, 2);
        chk("t2_req_low", imem_req, 0);
        chk("t2_valid", exec_valid, 1);
        chk("t2_head", {exec_pc, exec}, {16'h0000, 16'hC010});
        exec_ready = 1'b1;
        tick();
        exec_ready = 1'b0;
        chk("t2_req_again", imem_req, 1);
        chk("t2_addr2", imem_addr, 16'h0002);
        chk("t2_head1", exec_pc, 16'h0001);
        repeat (4) tick();
        chk("t2_acks3", ack_count, 3);
        chk("t2_req_low2", imem_req, 0);

        // Redirect hits an outstanding request for address 5
        exec_ready = 1'b1;
        ack_delay  = 3;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if (imem_req && imem_addr == 16'h0005 && !imem_ack) break;
            tick();
        end
        chk("t3_req5", imem_req && imem_addr == 16'h0005, 1);
        br_target = 16'h0040;
        br_taken  = 1'b1;
        tick();
        br_taken = 1'b0;
        chk("t3_drain_req", imem_req, 1);
        chk("t3_drain_addr", imem_addr, 16'h0005);
        chk("t3_flushed", exec_valid, 0);
        wait_req_addr("t3_new_addr", 16'h0040);
        wait_valid("t3_valid");
        chk("t3_pc", exec_pc, 16'h0040);
        chk("t3_exec", exec, 16'hC410);

        // Redirect in the same cycle as an ack and a pop
        ack_delay  = 0;
        exec_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (imem_ack && exec_valid) break;
            tick();
        end
        chk("t4_ack_pop", imem_ack && exec_valid, 1);
        br_target = 16'h0080;
        br_taken  = 1'b1;
        tick();
        br_taken = 1'b0;
        chk("t4_flushed", exec_valid, 0);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 16'h0080);
        wait_valid("t4_valid");
        chk("t4_pc", exec_pc, 16'h0080);
        chk("t4_exec", exec, 16'hC810);

        // Reset while a request is outstanding and one word is queued
        ack_delay  = 2;
        exec_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (exec_valid && imem_req && !imem_ack) break;
            tick();
        end
        chk("t6_setup", exec_valid && imem_req, 1);
        RESET = 1'b1;
        tick();
        chk("t6_req", imem_req, 0);
        chk("t6_valid", exec_valid, 0);
        chk("t6_exec", exec, 16'h0000);
        RESET = 1'b0;
        tick();
        chk("t6_req_again", imem_req, 1);
        chk("t6_addr", imem_addr, 16'h0000);

        // Branch near the top of the address space wraps to zero
        ack_delay  = 0;
        exec_ready = 1'b1;
        br_target  = 16'hFFFE;
        br_taken   = 1'b1;
        tick();
        br_taken = 1'b0;
        wait_req_addr("t7_ffff", 16'hFFFF);
        wait_req_addr("t7_0000", 16'h0000);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
